// File: rtl/scs8hd_rrarb3_1.sv
// Registered 3-way round-robin arbiter (A, B, C) with hold timeout.
// A and B are qualified by their enables; C is unqualified, matching an a221o AND-OR.
module scs8hd_rrarb3_1 #(
  parameter int HOLD_MAX = 15,
  parameter int CW       = 4
) (
`ifdef SC_USE_PG_PIN
  input  logic       vpwr,
  input  logic       vgnd,
  input  logic       vpb,
  input  logic       vnb,
`endif
  input  logic       CLK,
  input  logic       RESETB,
  input  logic       REQ_A,
  input  logic       EN_A,
  input  logic       REQ_B,
  input  logic       EN_B,
  input  logic       REQ_C,
  input  logic       DONE,
  output logic       GNT_A,
  output logic       GNT_B,
  output logic       GNT_C,
  output logic       BUSY,
  output logic       TMO,
  output logic       ANY,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

  state_t        state_q, state_d;
  logic [2:0]    gnt_q, gnt_d;     // bit 0 = A, bit 1 = B, bit 2 = C
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    last_q, last_d;   // index of the previous owner: 0 = A, 1 = B, 2 = C
  logic [2:0]    req;
  logic [2:0]    win;
  logic [1:0]    owner_idx;
  logic          owner_req;
  logic          tmo;

  assign req = {REQ_C, REQ_B & EN_B, REQ_A & EN_A};
  assign ANY = |req;

  // Rotating priority: the requester after the previous owner is searched first.
  always_comb begin
    win = 3'b000;
    case (last_q)
      2'd0: begin
        if      (req[1]) win = 3'b010;
        else if (req[2]) win = 3'b100;
        else if (req[0]) win = 3'b001;
      end
      2'd1: begin
        if      (req[2]) win = 3'b100;
        else if (req[0]) win = 3'b001;
        else if (req[1]) win = 3'b010;
      end
      default: begin
        if      (req[0]) win = 3'b001;
        else if (req[1]) win = 3'b010;
        else if (req[2]) win = 3'b100;
      end
    endcase
  end

  assign owner_idx = gnt_q[1] ? 2'd1 : (gnt_q[2] ? 2'd2 : 2'd0);
  assign owner_req = |(gnt_q & req);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    tmo     = 1'b0;
    case (state_q)
      S_GRANT: begin
        if (DONE || !owner_req || (cnt_q == CNT_LAST)) begin
          // DONE and request drop take precedence, so TMO flags only a true timeout.
          tmo     = !DONE && owner_req;
          gnt_d   = 3'b000;
          busy_d  = 1'b0;
          last_d  = owner_idx;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        if (|req) begin
          gnt_d   = win;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_GRANT;
        end else begin
          gnt_d   = 3'b000;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q <= S_IDLE;
      gnt_q   <= 3'b000;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 2'd2;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign GNT_A       = gnt_q[0];
  assign GNT_B       = gnt_q[1];
  assign GNT_C       = gnt_q[2];
  assign BUSY        = busy_q;
  assign TMO         = tmo;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_scs8hd_rrarb3_1.sv
// Bench for scs8hd_rrarb3_1: ANY vector table, scripted corner sequences,
// and randomized traffic checked against an owner/hold-count reference model.
module tb_scs8hd_rrarb3_1;

  localparam int HOLD_MAX = 15;

  logic       CLK = 1'b0;
  logic       RESETB = 1'b0;
  logic       REQ_A = 1'b0, EN_A = 1'b0, REQ_B = 1'b0, EN_B = 1'b0, REQ_C = 1'b0, DONE = 1'b0;
  logic       GNT_A, GNT_B, GNT_C, BUSY, TMO, ANY;
  logic [1:0] dbg_state;

  scs8hd_rrarb3_1 #(.HOLD_MAX(HOLD_MAX), .CW(4)) dut (
`ifdef SC_USE_PG_PIN
    .vpwr(1'b1), .vgnd(1'b0), .vpb(1'b1), .vnb(1'b0),
`endif
    .CLK(CLK), .RESETB(RESETB),
    .REQ_A(REQ_A), .EN_A(EN_A), .REQ_B(REQ_B), .EN_B(EN_B), .REQ_C(REQ_C),
    .DONE(DONE),
    .GNT_A(GNT_A), .GNT_B(GNT_B), .GNT_C(GNT_C),
    .BUSY(BUSY), .TMO(TMO), .ANY(ANY),
    .dbg_state_o(dbg_state)
  );

  // Clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model: current owner (-1 = none), cycles held so far, previous owner.
  int   m_own  = -1;
  int   m_held = 0;
  int   m_last = 2;
  logic obs_tmo;

  logic [2:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] gnt_vec();
    return {GNT_C, GNT_B, GNT_A};
  endfunction

  // Called at posedge+1: applies inputs for one cycle, checks combinational
  // outputs before the edge and registered outputs after it.
  task automatic drive_cycle(input logic ra, input logic ea, input logic rb,
                             input logic eb, input logic rc, input logic d);
    bit q[3];
    int nxt_own, nxt_held, nxt_last;
    bit exp_tmo, exp_any;
    REQ_A = ra; EN_A = ea; REQ_B = rb; EN_B = eb; REQ_C = rc; DONE = d;
    #1;
    q[0] = ra && ea;
    q[1] = rb && eb;
    q[2] = rc;
    exp_any  = q[0] || q[1] || q[2];
    exp_tmo  = 1'b0;
    nxt_own  = m_own;
    nxt_held = m_held;
    nxt_last = m_last;
    if (m_own >= 0) begin
      if (d || !q[m_own] || m_held == HOLD_MAX) begin
        exp_tmo  = !d && q[m_own] && (m_held == HOLD_MAX);
        nxt_last = m_own;
        nxt_own  = -1;
      end else begin
        nxt_held = m_held + 1;
      end
    end else begin
      for (int k = 1; k <= 3; k++) begin
        int c;
        c = (m_last + k) % 3;
        if (q[c] && nxt_own < 0) begin
          nxt_own  = c;
          nxt_held = 1;
        end
      end
    end
    obs_tmo = TMO;
    check("any", {31'd0, ANY}, {31'd0, exp_any});
    check("tmo", {31'd0, TMO}, {31'd0, exp_tmo});
    @(posedge CLK);
    #1;
    m_own  = nxt_own;
    m_held = nxt_held;
    m_last = nxt_last;
    check("gnt", {29'd0, gnt_vec()}, (m_own >= 0) ? (32'd1 << m_own) : 32'd0);
    check("busy", {31'd0, BUSY}, {31'd0, (m_own >= 0)});
  endtask

  // Asserts reset away from any clock edge and checks outputs drop without a clock.
  task automatic do_reset();
    REQ_A = 0; EN_A = 0; REQ_B = 0; EN_B = 0; REQ_C = 0; DONE = 0;
    RESETB = 1'b0;
    #3;
    check("rst_gnt", {29'd0, gnt_vec()}, 32'd0);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_tmo", {31'd0, TMO}, 32'd0);
    m_own = -1; m_held = 0; m_last = 2;
    @(negedge CLK);
    RESETB = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic ra, ea, rb, eb, rc;
    logic exp_any;
  } any_vec_t;

  any_vec_t tbl[8];

  initial begin
    int cnt_a, cnt_tmo;
    logic [2:0] exp_g;

    tbl[0] = '{1, 1, 0, 0, 0, 1};
    tbl[1] = '{1, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 0, 1, 1, 0, 1};
    tbl[3] = '{0, 0, 1, 0, 0, 0};
    tbl[4] = '{0, 0, 0, 0, 1, 1};
    tbl[5] = '{0, 1, 0, 1, 0, 0};
    tbl[6] = '{1, 0, 1, 0, 1, 1};
    tbl[7] = '{0, 0, 0, 0, 0, 0};

    do_reset();

    // ANY truth table, applied within one cycle so no edge sees the inputs.
    for (int i = 0; i < 8; i++) begin
      REQ_A = tbl[i].ra; EN_A = tbl[i].ea; REQ_B = tbl[i].rb; EN_B = tbl[i].eb; REQ_C = tbl[i].rc;
      #1;
      check("any_tbl", {31'd0, ANY}, {31'd0, tbl[i].exp_any});
    end
    REQ_A = 0; EN_A = 0; REQ_B = 0; EN_B = 0; REQ_C = 0;
    @(posedge CLK);
    #1;

    // Single grant to A, released by DONE.
    drive_cycle(1, 1, 0, 0, 0, 0);
    check("t1_gnt_a", {31'd0, GNT_A}, 32'd1);
    for (int i = 0; i < 3; i++) drive_cycle(1, 1, 0, 0, 0, 0);
    drive_cycle(1, 1, 0, 0, 0, 1);
    check("t1_release", {29'd0, gnt_vec(), BUSY}, 32'd0);
    drive_cycle(0, 0, 0, 0, 0, 0);

    // All requesting, DONE two cycles after each grant: A, B, C, A.
    do_reset();
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b001);
    while (exp_q.size() > 0) begin
      drive_cycle(1, 1, 1, 1, 1, 0);
      exp_g = exp_q.pop_front();
      check("t2_order", {29'd0, gnt_vec()}, {29'd0, exp_g});
      drive_cycle(1, 1, 1, 1, 1, 0);
      drive_cycle(1, 1, 1, 1, 1, 1);
      check("t2_gap", {29'd0, gnt_vec()}, 32'd0);
    end

    // Disabled A is invisible; C then wins.
    do_reset();
    drive_cycle(1, 0, 0, 0, 0, 0);
    drive_cycle(1, 0, 0, 0, 0, 0);
    drive_cycle(1, 0, 0, 0, 1, 0);
    check("t3_gnt_c", {29'd0, gnt_vec()}, 32'b100);
    drive_cycle(1, 0, 0, 0, 1, 1);

    // Hold timeout with A and B requesting.
    do_reset();
    cnt_a = 0;
    cnt_tmo = 0;
    for (int i = 0; i < 17; i++) begin
      drive_cycle(1, 1, 1, 1, 0, 0);
      if (obs_tmo) cnt_tmo++;
      if (GNT_A) cnt_a++;
    end
    check("t4_hold_cycles", cnt_a, HOLD_MAX);
    check("t4_tmo_pulses", cnt_tmo, 1);
    check("t4_gnt_b", {29'd0, gnt_vec()}, 32'b010);

    // Async reset while B owns the resource, then A wins first.
    do_reset();
    drive_cycle(1, 1, 1, 1, 0, 0);
    check("t5_gnt_a", {29'd0, gnt_vec()}, 32'b001);
    drive_cycle(1, 1, 1, 1, 0, 1);

    // DONE on the final allowed cycle suppresses TMO.
    do_reset();
    drive_cycle(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < HOLD_MAX - 1; i++) drive_cycle(1, 1, 0, 0, 0, 0);
    drive_cycle(1, 1, 0, 0, 0, 1);
    check("t6_tmo", {31'd0, obs_tmo}, 32'd0);
    check("t6_gnt_a", {31'd0, GNT_A}, 32'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      drive_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
